// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin sharing of an external AND/OR/NOT gate unit between two requesters
module gate_unit_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iReq0,
  input  logic [WIDTH-1:0] iA0,
  input  logic [WIDTH-1:0] iB0,
  input  logic [1:0]       iOp0,
  output logic             oGnt0,
  output logic [WIDTH-1:0] oRes0,
  output logic             oVld0,
  input  logic             iReq1,
  input  logic [WIDTH-1:0] iA1,
  input  logic [WIDTH-1:0] iB1,
  input  logic [1:0]       iOp1,
  output logic             oGnt1,
  output logic [WIDTH-1:0] oRes1,
  output logic             oVld1,
  output logic [WIDTH-1:0] oGateA,
  output logic [WIDTH-1:0] oGateB,
  input  logic [WIDTH-1:0] iGateAnd,
  input  logic [WIDTH-1:0] iGateOr,
  input  logic [WIDTH-1:0] iGateNot,
  output logic             oBusy
);

  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rr, w_rr_nxt;
  logic             r_owner, w_owner_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [WIDTH-1:0] r_gate_a, w_gate_a_nxt;
  logic [WIDTH-1:0] r_gate_b, w_gate_b_nxt;
  logic [WIDTH-1:0] r_res0, w_res0_nxt;
  logic [WIDTH-1:0] r_res1, w_res1_nxt;
  logic             r_gnt0, w_gnt0_nxt;
  logic             r_gnt1, w_gnt1_nxt;
  logic             r_vld0, w_vld0_nxt;
  logic             r_vld1, w_vld1_nxt;
  logic             w_win;
  logic [WIDTH-1:0] w_sel;

  // Port 1 wins when it is the only requester, or on a tie when rr points at it.
  assign w_win = iReq1 & (~iReq0 | r_rr);

  always_comb begin
    w_sel = '0;
    case (r_op)
      2'b00:   w_sel = iGateAnd;
      2'b01:   w_sel = iGateOr;
      2'b10:   w_sel = iGateNot;
      default: w_sel = '0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr;
    w_owner_nxt  = r_owner;
    w_op_nxt     = r_op;
    w_gate_a_nxt = r_gate_a;
    w_gate_b_nxt = r_gate_b;
    w_res0_nxt   = r_res0;
    w_res1_nxt   = r_res1;
    w_gnt0_nxt   = 1'b0;
    w_gnt1_nxt   = 1'b0;
    w_vld0_nxt   = 1'b0;
    w_vld1_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (iReq0 || iReq1) begin
          w_owner_nxt  = w_win;
          w_op_nxt     = w_win ? iOp1 : iOp0;
          w_gate_a_nxt = w_win ? iA1 : iA0;
          w_gate_b_nxt = w_win ? iB1 : iB0;
          w_gnt0_nxt   = ~w_win;
          w_gnt1_nxt   = w_win;
          w_state_nxt  = EVAL;
        end
      end
      EVAL: begin
        if (r_owner) begin
          w_res1_nxt = w_sel;
          w_vld1_nxt = 1'b1;
        end else begin
          w_res0_nxt = w_sel;
          w_vld0_nxt = 1'b1;
        end
        w_rr_nxt    = ~r_owner;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= IDLE;
      r_rr     <= 1'b0;
      r_owner  <= 1'b0;
      r_op     <= 2'b00;
      r_gate_a <= '0;
      r_gate_b <= '0;
      r_res0   <= '0;
      r_res1   <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_vld0   <= 1'b0;
      r_vld1   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr     <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_op     <= w_op_nxt;
      r_gate_a <= w_gate_a_nxt;
      r_gate_b <= w_gate_b_nxt;
      r_res0   <= w_res0_nxt;
      r_res1   <= w_res1_nxt;
      r_gnt0   <= w_gnt0_nxt;
      r_gnt1   <= w_gnt1_nxt;
      r_vld0   <= w_vld0_nxt;
      r_vld1   <= w_vld1_nxt;
    end
  end

  assign oGnt0  = r_gnt0;
  assign oGnt1  = r_gnt1;
  assign oVld0  = r_vld0;
  assign oVld1  = r_vld1;
  assign oRes0  = r_res0;
  assign oRes1  = r_res1;
  assign oGateA = r_gate_a;
  assign oGateB = r_gate_b;
  assign oBusy  = (r_state == EVAL);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb/tb_gate_unit_arbiter.sv - directed and random checks of gate_unit_arbiter against a transaction model
module tb_gate_unit_arbiter;
  localparam int W = 4;

  logic         iClk = 1'b0;
  logic         iRst_n;
  logic         iReq0, iReq1;
  logic [W-1:0] iA0, iB0, iA1, iB1;
  logic [1:0]   iOp0, iOp1;
  logic         oGnt0, oGnt1, oVld0, oVld1, oBusy;
  logic [W-1:0] oRes0, oRes1, oGateA, oGateB;
  logic [W-1:0] iGateAnd, iGateOr, iGateNot;

  int n_vec = 0;
  int n_err = 0;

  gate_unit_arbiter #(.WIDTH(W)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iReq0(iReq0), .iA0(iA0), .iB0(iB0), .iOp0(iOp0),
    .oGnt0(oGnt0), .oRes0(oRes0), .oVld0(oVld0),
    .iReq1(iReq1), .iA1(iA1), .iB1(iB1), .iOp1(iOp1),
    .oGnt1(oGnt1), .oRes1(oRes1), .oVld1(oVld1),
    .oGateA(oGateA), .oGateB(oGateB),
    .iGateAnd(iGateAnd), .iGateOr(iGateOr), .iGateNot(iGateNot),
    .oBusy(oBusy)
  );

  // External gate unit.
  assign iGateAnd = oGateA & oGateB;
  assign iGateOr  = oGateA | oGateB;
  assign iGateNot = ~oGateA;

  always #5 iClk = ~iClk;

  function automatic logic [W-1:0] op_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic rr);
    if (r0 && !r1) return 1'b0;
    if (r1 && !r0) return 1'b1;
    return rr;
  endfunction

  // Transaction model: an accepted request yields its grant next cycle and its result one cycle later.
  logic         m_busy, m_rr, m_owner, m_gnt0, m_gnt1, m_vld0, m_vld1;
  logic [W-1:0] m_pend, m_res0, m_res1, m_ga, m_gb;

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_busy <= 0; m_rr <= 0; m_owner <= 0; m_gnt0 <= 0; m_gnt1 <= 0;
      m_vld0 <= 0; m_vld1 <= 0; m_pend <= '0; m_res0 <= '0; m_res1 <= '0;
      m_ga <= '0; m_gb <= '0;
    end else if (!m_busy) begin
      m_vld0 <= 0;
      m_vld1 <= 0;
      if (iReq0 || iReq1) begin
        m_owner <= pick(iReq0, iReq1, m_rr);
        m_ga    <= pick(iReq0, iReq1, m_rr) ? iA1 : iA0;
        m_gb    <= pick(iReq0, iReq1, m_rr) ? iB1 : iB0;
        m_pend  <= pick(iReq0, iReq1, m_rr) ? op_result(iA1, iB1, iOp1)
                                            : op_result(iA0, iB0, iOp0);
        m_gnt0  <= !pick(iReq0, iReq1, m_rr);
        m_gnt1  <= pick(iReq0, iReq1, m_rr);
        m_busy  <= 1;
      end else begin
        m_gnt0 <= 0;
        m_gnt1 <= 0;
      end
    end else begin
      m_gnt0 <= 0;
      m_gnt1 <= 0;
      m_vld0 <= !m_owner;
      m_vld1 <= m_owner;
      if (m_owner) m_res1 <= m_pend;
      else         m_res0 <= m_pend;
      m_rr   <= !m_owner;
      m_busy <= 0;
    end
  end

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    cmp("gnt0",  W'(oGnt0), W'(m_gnt0));
    cmp("gnt1",  W'(oGnt1), W'(m_gnt1));
    cmp("vld0",  W'(oVld0), W'(m_vld0));
    cmp("vld1",  W'(oVld1), W'(m_vld1));
    cmp("busy",  W'(oBusy), W'(m_busy));
    cmp("res0",  oRes0, m_res0);
    cmp("res1",  oRes1, m_res1);
    cmp("gateA", oGateA, m_ga);
    cmp("gateB", oGateB, m_gb);
    cmp("pulse_overlap", W'(oVld0 & oVld1 | oGnt0 & oGnt1), '0);
  end

  task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    if (p == 0) begin iReq0 = 1; iA0 = a; iB0 = b; iOp0 = op; end
    else        begin iReq1 = 1; iA1 = a; iB1 = b; iOp1 = op; end
  endtask

  // Single-requester op: grant one cycle after the sampling edge, result one cycle after that.
  task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [W-1:0] exp);
    set_req(p, a, b, op);
    @(posedge iClk); #2;
    cmp("lit_gnt", W'({oGnt1, oGnt0}), (p == 0) ? W'(1) : W'(2));
    cmp("lit_busy_g", W'(oBusy), W'(1));
    iReq0 = 0; iReq1 = 0;
    @(posedge iClk); #2;
    cmp("lit_vld", W'({oVld1, oVld0}), (p == 0) ? W'(1) : W'(2));
    cmp("lit_busy_v", W'(oBusy), W'(0));
    cmp("lit_res", (p == 0) ? oRes0 : oRes1, exp);
  endtask

  task automatic check_all_zero();
    cmp("rst_outs", W'({oGnt0, oGnt1, oVld0, oVld1}), '0);
    cmp("rst_busy", W'(oBusy), '0);
    cmp("rst_res",  oRes0 | oRes1, '0);
    cmp("rst_gate", oGateA | oGateB, '0);
  endtask

  initial begin
    iRst_n = 0; iReq0 = 0; iReq1 = 0;
    iA0 = '0; iB0 = '0; iOp0 = '0; iA1 = '0; iB1 = '0; iOp1 = '0;
    repeat (2) @(posedge iClk);
    #2; check_all_zero();
    iRst_n = 1;

    do_op(0, 4'b0001, 4'b0000, 2'b00, 4'b0000);
    do_op(0, 4'b0001, 4'b0000, 2'b01, 4'b0001);
    do_op(0, 4'b0001, 4'b0000, 2'b10, 4'b1110);

    do_op(1, 4'b1100, 4'b1010, 2'b00, 4'b1000);
    cmp("res0_held", oRes0, 4'b1110);
    do_op(1, 4'b1100, 4'b1010, 2'b01, 4'b1110);
    do_op(1, 4'b1100, 4'b1010, 2'b10, 4'b0011);
    do_op(1, 4'b1100, 4'b1010, 2'b11, 4'b0000);
    cmp("res0_held", oRes0, 4'b1110);

    // Leave rr pointing at port 1, then kill port 1's op mid-flight.
    do_op(0, 4'b0110, 4'b0011, 2'b00, 4'b0010);
    set_req(1, 4'b1111, 4'b1111, 2'b01);
    @(posedge iClk); #2;
    cmp("pre_rst_gnt1", W'(oGnt1), W'(1));
    iReq1 = 0;
    iRst_n = 0;
    #1; check_all_zero();
    #1; iRst_n = 1;
    @(posedge iClk); #2;
    cmp("no_vld_after_rst", W'({oVld1, oVld0}), '0);

    set_req(0, 4'b1010, 4'b0110, 2'b00);
    set_req(1, 4'b0101, 4'b0011, 2'b01);
    @(posedge iClk); #2;
    cmp("tie_gnt0_first", W'({oGnt1, oGnt0}), W'(1));
    iReq0 = 0;
    @(posedge iClk); #2;
    cmp("tie_vld0", W'({oVld1, oVld0}), W'(1));
    cmp("tie_res0", oRes0, 4'b0010);
    @(posedge iClk); #2;
    cmp("tie_gnt1_second", W'({oGnt1, oGnt0}), W'(2));
    iReq1 = 0;
    @(posedge iClk); #2;
    cmp("tie_vld1", W'({oVld1, oVld0}), W'(2));
    cmp("tie_res1", oRes1, 4'b0111);

    set_req(0, 4'b0011, 4'b0101, 2'b01);
    set_req(1, 4'b0011, 4'b0101, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(posedge iClk); #2;
      if (i % 2 == 0) cmp("alt_gnt", W'({oGnt1, oGnt0}), ((i / 2) % 2 == 0) ? W'(1) : W'(2));
      else            cmp("alt_vld", W'({oVld1, oVld0}), ((i / 2) % 2 == 0) ? W'(1) : W'(2));
    end
    iReq0 = 0; iReq1 = 0;

    for (int i = 0; i < 400; i++) begin
      @(posedge iClk); #2;
      iReq0 = ($urandom_range(0, 3) != 0);
      iReq1 = ($urandom_range(0, 2) != 0);
      iA0 = W'($urandom); iB0 = W'($urandom); iOp0 = 2'($urandom);
      iA1 = W'($urandom); iB1 = W'($urandom); iOp1 = 2'($urandom);
      if (i == 200) begin
        iRst_n = 0;
        #1; check_all_zero();
        #1; iRst_n = 1;
      end
    end
    iReq0 = 0; iReq1 = 0;
    repeat (4) @(posedge iClk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
